rdwr_tx_arb: RTL and testbench

Shares one fabric request channel between the streaming read/write test engine and the DSM status writer. Each cycle it grants at most one request: a read, a test write, or a status write. It generates the per-requester `Sent` handshakes and keeps multi-CL write bursts unbroken. It also enforces a read-credit limit against outstanding read responses and drives a registered request to the fabric.

---
 rtl/rdwr_arb_pkg.sv | 24 ++
 rtl/rd_credit_ctr.sv | 45 ++++
 rtl/rdwr_tx_arb.sv | 178 +++++++++++++++++
 tb/tb_rdwr_tx_arb.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdwr_arb_pkg.sv
// Shared types for the read/write fabric request arbiter.
//   arb_state_e : arbiter state (free arbitration or locked write burst)
//   DSM_TID     : transaction id stamped on status writes
//   tx_req_t    : registered fabric request (address is kept separately
//                 because its width is a parameter of the top module)
package rdwr_arb_pkg;

  typedef enum logic {
    ARB      = 1'b0,
    WR_BURST = 1'b1
  } arb_state_e;

  localparam logic [15:0] DSM_TID = 16'hFFFF;

  typedef struct packed {
    logic         valid;
    logic         is_wr;
    logic [15:0]  tid;
    logic [511:0] data;
    logic [1:0]   len;
    logic         sop;
  } tx_req_t;

endpackage

// File: rtl/rd_credit_ctr.sv
// Outstanding read-CL counter.
//   clk, srst   : clock, synchronous active-high reset
//   rd_grant    : a read was granted this cycle
//   rd_len      : length (CLs-1) of the read being offered/granted
//   rsp_valid   : one read-response CL returned this cycle
//   rd_pend     : outstanding read CLs
//   rd_elig     : the offered read fits under MAX_RD_PEND
//   underflow   : response arrived with nothing outstanding
module rd_credit_ctr #(
  parameter int MAX_RD_PEND = 512
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       rd_grant,
  input  logic [1:0] rd_len,
  input  logic       rsp_valid,
  output logic [9:0] rd_pend,
  output logic       rd_elig,
  output logic       underflow
);

  logic [10:0] need;
  logic [10:0] add;
  logic [10:0] pend_next;
  logic        dec;

  // 11-bit sum so a near-full counter plus a 4-CL read cannot wrap.
  assign need      = {1'b0, rd_pend} + 11'(rd_len) + 11'd1;
  assign rd_elig   = (need <= 11'(MAX_RD_PEND));

  // A response with nothing outstanding is an error and is not counted.
  assign underflow = rsp_valid && (rd_pend == 10'd0);
  assign dec       = rsp_valid && (rd_pend != 10'd0);
  assign add       = rd_grant ? (11'(rd_len) + 11'd1) : 11'd0;
  assign pend_next = {1'b0, rd_pend} + add - (dec ? 11'd1 : 11'd0);

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_pend <= '0;
    end else begin
      rd_pend <= pend_next[9:0];
    end
  end

endmodule

// File: rtl/rdwr_tx_arb.sv
// Arbiter sharing one fabric request channel between the read/write test
// engine and the DSM status writer.
//   Clk_400, test_Reset          : clock, synchronous active-high reset
//   rw2ab_Rd*  / ab2rw_RdSent    : read requests and their grant
//   rw2ab_Wr*  / ab2rw_WrSent    : test-write beats and their grant
//   ab2rw_WrAlmFull              : fabric almost-full echoed to the engine
//   dsm_Wr*    / dsm_WrSent      : single-CL status writes and their grant
//   tx_*                         : registered request to the fabric
//   tx_AlmFull                   : fabric backpressure, blocks all grants
//   rx_RdRspValid / rd_Pend      : read-response return, outstanding CLs
//   err_Proto                    : sticky protocol error
module rdwr_tx_arb
  import rdwr_arb_pkg::*;
#(
  parameter int ADDR_LMT    = 20,
  parameter int MAX_RD_PEND = 512
) (
  input  logic                Clk_400,
  input  logic                test_Reset,
  input  logic                rw2ab_RdEn,
  input  logic [ADDR_LMT-1:0] rw2ab_RdAddr,
  input  logic [15:0]         rw2ab_RdTID,
  input  logic [1:0]          rw2ab_RdLen,
  input  logic                rw2ab_RdSop,
  output logic                ab2rw_RdSent,
  input  logic                rw2ab_WrEn,
  input  logic [ADDR_LMT-1:0] rw2ab_WrAddr,
  input  logic [15:0]         rw2ab_WrTID,
  input  logic [511:0]        rw2ab_WrDin,
  input  logic [1:0]          rw2ab_WrLen,
  input  logic                rw2ab_WrSop,
  output logic                ab2rw_WrSent,
  output logic                ab2rw_WrAlmFull,
  input  logic                dsm_WrEn,
  input  logic [ADDR_LMT-1:0] dsm_WrAddr,
  input  logic [511:0]        dsm_WrDin,
  output logic                dsm_WrSent,
  output logic                tx_Valid,
  output logic                tx_IsWr,
  output logic [ADDR_LMT-1:0] tx_Addr,
  output logic [15:0]         tx_TID,
  output logic [511:0]        tx_Data,
  output logic [1:0]          tx_Len,
  output logic                tx_Sop,
  input  logic                tx_AlmFull,
  input  logic                rx_RdRspValid,
  output logic [9:0]          rd_Pend,
  output logic                err_Proto
);

  arb_state_e          state_reg;
  logic [1:0]          beats_left_reg;
  logic                last_wr_reg;
  logic                err_reg;
  tx_req_t             tx_reg;
  logic [ADDR_LMT-1:0] tx_addr_reg;

  logic grant_rd, grant_wr, grant_dsm;
  logic rd_elig, rd_req, wr_req, underflow, proto_err;

  rd_credit_ctr #(.MAX_RD_PEND(MAX_RD_PEND)) u_credit (
    .clk       (Clk_400),
    .srst      (test_Reset),
    .rd_grant  (grant_rd),
    .rd_len    (rw2ab_RdLen),
    .rsp_valid (rx_RdRspValid),
    .rd_pend   (rd_Pend),
    .rd_elig   (rd_elig),
    .underflow (underflow)
  );

  // Outside a burst, only a start-of-packet beat may open a write.
  assign rd_req = rw2ab_RdEn && rd_elig;
  assign wr_req = rw2ab_WrEn && rw2ab_WrSop;

  always_comb begin
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    grant_dsm = 1'b0;
    if (!test_Reset && !tx_AlmFull) begin
      if (state_reg == WR_BURST) begin
        grant_wr = rw2ab_WrEn;
      end else if (dsm_WrEn) begin
        grant_dsm = 1'b1;
      end else if (rd_req && wr_req) begin
        // Tie goes to whoever did not win the previous read/write grant.
        grant_rd = last_wr_reg;
        grant_wr = !last_wr_reg;
      end else begin
        grant_rd = rd_req;
        grant_wr = wr_req;
      end
    end
  end

  assign proto_err = underflow
                  || (rw2ab_WrEn && (state_reg == WR_BURST) && rw2ab_WrSop)
                  || (rw2ab_WrEn && (state_reg == ARB) && !rw2ab_WrSop);

  always_ff @(posedge Clk_400) begin
    if (test_Reset) begin
      state_reg      <= ARB;
      beats_left_reg <= '0;
      last_wr_reg    <= 1'b0;
      err_reg        <= 1'b0;
      tx_reg         <= '0;
      tx_addr_reg    <= '0;
    end else begin
      if (grant_rd) begin
        last_wr_reg <= 1'b0;
      end else if (grant_wr) begin
        last_wr_reg <= 1'b1;
      end

      if (proto_err) begin
        err_reg <= 1'b1;
      end

      case (state_reg)
        ARB: begin
          if (grant_wr && (rw2ab_WrLen != 2'd0)) begin
            beats_left_reg <= rw2ab_WrLen;
            state_reg      <= WR_BURST;
          end
        end
        WR_BURST: begin
          // A stray Sop here is only flagged; the beat still counts down.
          if (grant_wr) begin
            beats_left_reg <= beats_left_reg - 2'd1;
            if (beats_left_reg == 2'd1) begin
              state_reg <= ARB;
            end
          end
        end
        default: state_reg <= ARB;
      endcase

      tx_reg      <= '0;
      tx_addr_reg <= '0;
      if (grant_rd) begin
        tx_reg.valid <= 1'b1;
        tx_reg.tid   <= rw2ab_RdTID;
        tx_reg.len   <= rw2ab_RdLen;
        tx_reg.sop   <= rw2ab_RdSop;
        tx_addr_reg  <= rw2ab_RdAddr;
      end else if (grant_dsm) begin
        tx_reg.valid <= 1'b1;
        tx_reg.is_wr <= 1'b1;
        tx_reg.tid   <= DSM_TID;
        tx_reg.data  <= dsm_WrDin;
        tx_reg.sop   <= 1'b1;
        tx_addr_reg  <= dsm_WrAddr;
      end else if (grant_wr) begin
        tx_reg.valid <= 1'b1;
        tx_reg.is_wr <= 1'b1;
        tx_reg.tid   <= rw2ab_WrTID;
        tx_reg.data  <= rw2ab_WrDin;
        tx_reg.len   <= rw2ab_WrLen;
        tx_reg.sop   <= rw2ab_WrSop;
        tx_addr_reg  <= rw2ab_WrAddr;
      end
    end
  end

  assign ab2rw_RdSent    = grant_rd;
  assign ab2rw_WrSent    = grant_wr;
  assign dsm_WrSent      = grant_dsm;
  assign ab2rw_WrAlmFull = tx_AlmFull;
  assign err_Proto       = err_reg;
  assign tx_Valid        = tx_reg.valid;
  assign tx_IsWr         = tx_reg.is_wr;
  assign tx_Addr         = tx_addr_reg;
  assign tx_TID          = tx_reg.tid;
  assign tx_Data         = tx_reg.data;
  assign tx_Len          = tx_reg.len;
  assign tx_Sop          = tx_reg.sop;

endmodule

// File: tb/tb_rdwr_tx_arb.sv
module tb_rdwr_tx_arb;

  localparam int AW = 20;
  localparam logic [511:0] WDAT = {16{32'hCAFE_0001}};
  localparam logic [511:0] DDAT = {16{32'h5555_AAAA}};

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en, rd_sop, wr_en, wr_sop, dsm_en, alm_full, rsp;
  logic [AW-1:0] rd_addr, wr_addr, dsm_addr;
  logic [15:0]   rd_tid, wr_tid;
  logic [1:0]    rd_len, wr_len;
  logic [511:0]  wr_din, dsm_din;
  logic          rd_sent, wr_sent, wr_almfull, dsm_sent;
  logic          tx_valid, tx_iswr, tx_sop, err;
  logic [AW-1:0] tx_addr;
  logic [15:0]   tx_tid;
  logic [511:0]  tx_data;
  logic [1:0]    tx_len;
  logic [9:0]    rd_pend;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rdwr_tx_arb #(.ADDR_LMT(AW), .MAX_RD_PEND(8)) dut (
    .Clk_400(clk), .test_Reset(rst),
    .rw2ab_RdEn(rd_en), .rw2ab_RdAddr(rd_addr), .rw2ab_RdTID(rd_tid),
    .rw2ab_RdLen(rd_len), .rw2ab_RdSop(rd_sop), .ab2rw_RdSent(rd_sent),
    .rw2ab_WrEn(wr_en), .rw2ab_WrAddr(wr_addr), .rw2ab_WrTID(wr_tid),
    .rw2ab_WrDin(wr_din), .rw2ab_WrLen(wr_len), .rw2ab_WrSop(wr_sop),
    .ab2rw_WrSent(wr_sent), .ab2rw_WrAlmFull(wr_almfull),
    .dsm_WrEn(dsm_en), .dsm_WrAddr(dsm_addr), .dsm_WrDin(dsm_din),
    .dsm_WrSent(dsm_sent),
    .tx_Valid(tx_valid), .tx_IsWr(tx_iswr), .tx_Addr(tx_addr), .tx_TID(tx_tid),
    .tx_Data(tx_data), .tx_Len(tx_len), .tx_Sop(tx_sop),
    .tx_AlmFull(alm_full), .rx_RdRspValid(rsp),
    .rd_Pend(rd_pend), .err_Proto(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rd_en = 0; rd_sop = 1; rd_len = 0; rd_addr = 20'h00333; rd_tid = 16'h0044;
    wr_en = 0; wr_sop = 0; wr_len = 0; wr_addr = 20'h00111; wr_tid = 16'h0022;
    wr_din = WDAT; dsm_en = 0; dsm_addr = 20'h00777; dsm_din = DDAT;
    alm_full = 0; rsp = 0;
  endtask

  task automatic drain(input int n);
    rsp = 1;
    for (int i = 0; i < n; i++) tick;
    rsp = 0;
    nvec++;
    if (rd_pend !== 10'd0) begin
      nerr++; $display("FAIL drain_pend got %0d want 0", rd_pend);
    end
  endtask

  task automatic test_reset;
    idle;
    rst = 1; rd_en = 1; wr_en = 1; wr_sop = 1; dsm_en = 1;
    tick; tick;
    #3;
    nvec++;
    if ({wr_sent, dsm_sent, rd_sent} !== 3'b000) begin
      nerr++; $display("FAIL reset_sent got %b want 000", {wr_sent, dsm_sent, rd_sent});
    end
    nvec++;
    if ({tx_valid, tx_iswr, tx_sop, err} !== 4'b0000 || rd_pend !== 10'd0 || tx_data !== 512'd0) begin
      nerr++; $display("FAIL reset_out got v%b w%b s%b e%b pend %0d want all 0",
                       tx_valid, tx_iswr, tx_sop, err, rd_pend);
    end
    $display("reset: outputs checked");
    idle; rst = 0;
    tick;
  endtask

  task automatic test_round_robin;
    logic exp_r;
    idle;
    wr_en = 1; wr_sop = 1;
    #3;
    nvec++;
    if (wr_sent !== 1'b1) begin nerr++; $display("FAIL rr_lone_wr got %b want 1", wr_sent); end
    tick;
    nvec++;
    if (tx_valid !== 1'b1 || tx_iswr !== 1'b1 || tx_data !== WDAT) begin
      nerr++; $display("FAIL rr_lone_tx got v%b w%b want v1 w1 data", tx_valid, tx_iswr);
    end
    rd_en = 1;
    for (int i = 0; i < 4; i++) begin
      exp_r = (i % 2 == 0);
      #3;
      nvec++;
      if (rd_sent !== exp_r || wr_sent !== !exp_r) begin
        nerr++; $display("FAIL rr_grant cyc%0d got r%b w%b want r%b w%b", i, rd_sent, wr_sent, exp_r, !exp_r);
      end
      tick;
      $display("rr cyc %0d: tx_valid=%b tx_iswr=%b", i, tx_valid, tx_iswr);
      nvec++;
      if (tx_valid !== 1'b1 || tx_iswr !== !exp_r) begin
        nerr++; $display("FAIL rr_tx cyc%0d got v%b w%b want v1 w%b", i, tx_valid, tx_iswr, !exp_r);
      end
      nvec++;
      if (exp_r && (tx_data !== 512'd0 || tx_tid !== 16'h0044 || tx_addr !== 20'h00333)) begin
        nerr++; $display("FAIL rr_rdfields cyc%0d got tid %h addr %h want 0044 00333 data0", i, tx_tid, tx_addr);
      end else if (!exp_r && (tx_data !== WDAT || tx_tid !== 16'h0022)) begin
        nerr++; $display("FAIL rr_wrfields cyc%0d got tid %h want 0022", i, tx_tid);
      end
    end
    idle;
    tick;
    nvec++;
    if (tx_valid !== 1'b0) begin nerr++; $display("FAIL rr_idle_valid got %b want 0", tx_valid); end
    nvec++;
    if (rd_pend !== 10'd2) begin nerr++; $display("FAIL rr_pend got %0d want 2", rd_pend); end
    drain(2);
  endtask

  // st = {wr_en, wr_sop, dsm_en, rd_en}; ex = {WrSent, DsmSent, RdSent}
  task automatic test_burst_lock(input bit gap);
    logic [3:0] st [0:7];
    logic [2:0] ex [0:7];
    int n;
    if (!gap) begin
      n = 6;
      st[0] = 4'b1100; ex[0] = 3'b100;
      st[1] = 4'b1011; ex[1] = 3'b100;
      st[2] = 4'b1011; ex[2] = 3'b100;
      st[3] = 4'b1011; ex[3] = 3'b100;
      st[4] = 4'b0011; ex[4] = 3'b010;
      st[5] = 4'b0001; ex[5] = 3'b001;
    end else begin
      n = 8;
      st[0] = 4'b1100; ex[0] = 3'b100;
      st[1] = 4'b1011; ex[1] = 3'b100;
      st[2] = 4'b0011; ex[2] = 3'b000;
      st[3] = 4'b0011; ex[3] = 3'b000;
      st[4] = 4'b1011; ex[4] = 3'b100;
      st[5] = 4'b1011; ex[5] = 3'b100;
      st[6] = 4'b0011; ex[6] = 3'b010;
      st[7] = 4'b0001; ex[7] = 3'b001;
    end
    idle;
    wr_len = 2'd3;
    for (int i = 0; i < n; i++) begin
      {wr_en, wr_sop, dsm_en, rd_en} = st[i];
      #3;
      nvec++;
      if ({wr_sent, dsm_sent, rd_sent} !== ex[i]) begin
        nerr++; $display("FAIL burst_grant gap%0d cyc%0d got %b want %b", gap, i, {wr_sent, dsm_sent, rd_sent}, ex[i]);
      end
      tick;
      $display("burst gap%0d cyc %0d: tx_valid=%b tx_tid=%h", gap, i, tx_valid, tx_tid);
      nvec++;
      if (i == 0 && (tx_len !== 2'd3 || tx_sop !== 1'b1 || tx_iswr !== 1'b1)) begin
        nerr++; $display("FAIL burst_first gap%0d got len %0d sop %b want 3 1", gap, tx_len, tx_sop);
      end else if (ex[i] == 3'b010 && (tx_tid !== 16'hFFFF || tx_len !== 2'd0 || tx_sop !== 1'b1
                                       || tx_iswr !== 1'b1 || tx_data !== DDAT || tx_addr !== 20'h00777)) begin
        nerr++; $display("FAIL burst_dsm gap%0d got tid %h len %0d sop %b want ffff 0 1", gap, tx_tid, tx_len, tx_sop);
      end else if (tx_valid !== (ex[i] != 3'b000)) begin
        nerr++; $display("FAIL burst_valid gap%0d cyc%0d got %b want %b", gap, i, tx_valid, ex[i] != 3'b000);
      end
    end
    idle;
    tick;
    drain(1);
  endtask

  task automatic test_read_credits;
    logic [9:0] exp_pend [0:1];
    idle;
    rd_en = 1; rd_len = 2'd3;
    exp_pend[0] = 10'd4; exp_pend[1] = 10'd8;
    for (int i = 0; i < 2; i++) begin
      #3;
      nvec++;
      if (rd_sent !== 1'b1) begin nerr++; $display("FAIL cred_grant%0d got %b want 1", i, rd_sent); end
      tick;
      nvec++;
      if (rd_pend !== exp_pend[i]) begin nerr++; $display("FAIL cred_pend%0d got %0d want %0d", i, rd_pend, exp_pend[i]); end
    end
    #3;
    nvec++;
    if (rd_sent !== 1'b0) begin nerr++; $display("FAIL cred_full got %b want 0", rd_sent); end
    // One response: 7 + 4 still exceeds 8.
    rsp = 1; tick; rsp = 0;
    #3;
    nvec++;
    if (rd_sent !== 1'b0 || rd_pend !== 10'd7) begin
      nerr++; $display("FAIL cred_7 got sent %b pend %0d want 0 7", rd_sent, rd_pend);
    end
    rsp = 1;
    for (int i = 0; i < 3; i++) begin
      #3;
      nvec++;
      if (rd_sent !== 1'b0) begin nerr++; $display("FAIL cred_wait%0d got %b want 0", i, rd_sent); end
      tick;
    end
    rsp = 0;
    #3;
    nvec++;
    if (rd_sent !== 1'b1 || rd_pend !== 10'd4) begin
      nerr++; $display("FAIL cred_resume got sent %b pend %0d want 1 4", rd_sent, rd_pend);
    end
    tick;
    idle;
    $display("credits: pend=%0d after resume", rd_pend);
    nvec++;
    if (rd_pend !== 10'd8) begin nerr++; $display("FAIL cred_after got %0d want 8", rd_pend); end
    drain(8);
  endtask

  task automatic test_simultaneous;
    idle;
    rd_en = 1; rd_len = 2'd3;
    tick;
    rd_len = 2'd0;
    tick;
    nvec++;
    if (rd_pend !== 10'd5) begin nerr++; $display("FAIL simul_pre got %0d want 5", rd_pend); end
    rd_len = 2'd1; rsp = 1;
    #3;
    nvec++;
    if (rd_sent !== 1'b1) begin nerr++; $display("FAIL simul_grant got %b want 1", rd_sent); end
    tick;
    idle;
    nvec++;
    if (rd_pend !== 10'd6) begin nerr++; $display("FAIL simul_pend got %0d want 6", rd_pend); end
    drain(6);
  endtask

  task automatic test_backpressure;
    idle;
    dsm_en = 1; rd_en = 1; wr_en = 1; wr_sop = 1;
    tick;
    nvec++;
    if (tx_valid !== 1'b1 || tx_tid !== 16'hFFFF) begin
      nerr++; $display("FAIL bp_pre got v%b tid %h want 1 ffff", tx_valid, tx_tid);
    end
    alm_full = 1;
    for (int i = 0; i < 5; i++) begin
      #3;
      nvec++;
      if ({wr_sent, dsm_sent, rd_sent} !== 3'b000 || wr_almfull !== 1'b1) begin
        nerr++; $display("FAIL bp_sent cyc%0d got %b almfull %b want 000 1", i, {wr_sent, dsm_sent, rd_sent}, wr_almfull);
      end
      tick;
      nvec++;
      if (tx_valid !== 1'b0) begin nerr++; $display("FAIL bp_valid cyc%0d got %b want 0", i, tx_valid); end
    end
    alm_full = 0;
    #3;
    nvec++;
    if ({wr_sent, dsm_sent, rd_sent} !== 3'b010) begin
      nerr++; $display("FAIL bp_release got %b want 010", {wr_sent, dsm_sent, rd_sent});
    end
    tick;
    idle;
    tick;
    $display("backpressure: released");
  endtask

  task automatic test_reset_errors;
    idle;
    wr_en = 1; wr_sop = 1; wr_len = 2'd3;
    tick;
    wr_sop = 0;
    tick;
    rst = 1; dsm_en = 1; rd_en = 1;
    #3;
    nvec++;
    if ({wr_sent, dsm_sent, rd_sent} !== 3'b000) begin
      nerr++; $display("FAIL rst_mid_sent got %b want 000", {wr_sent, dsm_sent, rd_sent});
    end
    tick;
    nvec++;
    if ({tx_valid, tx_iswr, tx_sop, err} !== 4'b0000 || tx_tid !== 16'd0 || tx_addr !== 20'd0
        || tx_data !== 512'd0 || tx_len !== 2'd0 || rd_pend !== 10'd0) begin
      nerr++; $display("FAIL rst_mid_out got v%b tid %h len %0d want all 0", tx_valid, tx_tid, tx_len);
    end
    rst = 0; dsm_en = 0; rd_en = 0;
    #3;
    nvec++;
    if (wr_sent !== 1'b0) begin nerr++; $display("FAIL nosop_grant got %b want 0", wr_sent); end
    tick;
    wr_en = 0;
    nvec++;
    if (err !== 1'b1 || tx_valid !== 1'b0) begin
      nerr++; $display("FAIL nosop_err got err %b v %b want 1 0", err, tx_valid);
    end
    tick;
    nvec++;
    if (err !== 1'b1) begin nerr++; $display("FAIL err_sticky got %b want 1", err); end
    rst = 1; tick; rst = 0;
    nvec++;
    if (err !== 1'b0) begin nerr++; $display("FAIL err_clear got %b want 0", err); end
    rsp = 1; tick; rsp = 0;
    nvec++;
    if (err !== 1'b1 || rd_pend !== 10'd0) begin
      nerr++; $display("FAIL underflow got err %b pend %0d want 1 0", err, rd_pend);
    end
    $display("errors: err_Proto=%b rd_Pend=%0d", err, rd_pend);
  endtask

  initial begin
    idle;
    rst = 1;
    test_reset;
    test_round_robin;
    test_burst_lock(1'b0);
    test_burst_lock(1'b1);
    test_read_credits;
    test_simultaneous;
    test_backpressure;
    test_reset_errors;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
